// File: rtl/fsm_pkg.sv
// Shared definitions for the serializer feeding the 1001 sequence detector:
// FSM state encodings and the bit-counter width helper.
package fsm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // The counter must hold WIDTH-1, so it needs clog2(WIDTH) bits (at least one).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register for the serializer: captures a word accepted
// mid-frame and hands it to the shift register at the next word boundary.
module ser_hold_buf
  import fsm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full,
  output logic             load_ready
);

  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;

  // push only happens while empty and pop only while full, so they never collide
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (pop) begin
      hold_full_d = 1'b0;
    end
    if (push) begin
      hold_full_d = 1'b1;
      hold_data_d = push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign hold_data  = hold_data_q;
  assign hold_full  = hold_full_q;
  assign load_ready = !hold_full_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage driving the 1001 detector's serial input; a hold
// buffer lets consecutive words stream with no idle bit between them.
module seq_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             push;
  logic             pop;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  assign accept = load_valid && load_ready;

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (din),
    .hold_data (hold_data),
    .hold_full (hold_full),
    .load_ready(load_ready)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_d    = din;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        push = accept;
        if (bit_en) begin
          if (cnt_q != '0) begin
            sr_d  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
            cnt_d = cnt_q - 1'b1;
          end else if (hold_full) begin
            sr_d  = hold_data;
            cnt_d = CNT_LAST;
            pop   = 1'b1;
          end else if (accept) begin
            // A word offered exactly on the boundary bypasses the hold buffer
            sr_d  = din;
            cnt_d = CNT_LAST;
            push  = 1'b0;
          end else begin
            sr_d    = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Idle padding is forced to 0 so the detector never sees a fabricated 1
  assign out       = (state_q == ST_SHIFT) && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
  assign out_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: an MSB-first and an LSB-first instance
// share stimulus and are compared every cycle against a bit-queue model.
module tb_seq_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             bit_en;

  logic m_ready, m_out, m_valid, m_busy;
  logic l_ready, l_out, l_valid, l_busy;

  int tests = 0;
  int fails = 0;

  // Model: every pending bit (in-flight word plus held word) sits in a queue
  bit mq[$];
  bit lq[$];
  logic acc_m;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(m_ready), .bit_en(bit_en), .out(m_out),
    .out_valid(m_valid), .busy(m_busy)
  );

  seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(l_ready), .bit_en(bit_en), .out(l_out),
    .out_valid(l_valid), .busy(l_busy)
  );

  function automatic bit model_ready();
    return mq.size() <= WIDTH;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      lq.delete();
    end else begin
      acc_m = load_valid && (mq.size() <= WIDTH);
      if (bit_en && mq.size() > 0) void'(mq.pop_front());
      if (bit_en && lq.size() > 0) void'(lq.pop_front());
      if (acc_m) begin
        for (int i = WIDTH - 1; i >= 0; i--) mq.push_back(din[i]);
        for (int i = 0; i < WIDTH; i++) lq.push_back(din[i]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic v, input logic be);
    din        = d;
    load_valid = v;
    bit_en     = be;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the queue model on the falling edge
  always @(negedge clk) begin
    checkOutput("msb_out",   {31'd0, m_out},   {31'd0, (mq.size() > 0) ? mq[0] : 1'b0});
    checkOutput("msb_valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
    checkOutput("msb_ready", {31'd0, m_ready}, {31'd0, mq.size() <= WIDTH});
    checkOutput("msb_busy",  {31'd0, m_busy},  {31'd0, mq.size() > 0});
    checkOutput("lsb_out",   {31'd0, l_out},   {31'd0, (lq.size() > 0) ? lq[0] : 1'b0});
    checkOutput("lsb_valid", {31'd0, l_valid}, {31'd0, lq.size() > 0});
    checkOutput("lsb_ready", {31'd0, l_ready}, {31'd0, lq.size() <= WIDTH});
    checkOutput("lsb_busy",  {31'd0, l_busy},  {31'd0, lq.size() > 0});
  end

  initial begin
    logic [7:0]  rec8;
    logic [15:0] rec16;
    int hs;

    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_out",   {31'd0, m_out},   32'd0);
    checkOutput("reset_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("reset_ready", {31'd0, m_ready}, 32'd1);
    checkOutput("reset_busy",  {31'd0, m_busy},  32'd0);
    rst_n = 1'b1;
    tick();

    // Mid-word asynchronous reset after 3 bits of 0xA5
    applyStimulus(8'hA5, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out",   {31'd0, m_out},   32'd0);
    checkOutput("async_rst_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("async_rst_ready", {31'd0, m_ready}, 32'd1);
    checkOutput("async_rst_busy",  {31'd0, l_busy},  32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("post_rst_valid", {31'd0, m_valid}, 32'd0);

    // Single word 0x99, MSB first
    applyStimulus(8'h99, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rec8[7-i] = m_out;
      tick();
    end
    checkOutput("single_bits",  {24'd0, rec8}, 32'h99);
    checkOutput("single_idle",  {31'd0, m_valid}, 32'd0);
    tick();

    // Back-to-back 0xF0 then 0x0F with no gap
    applyStimulus(8'hF0, 1'b1, 1'b1);
    tick();
    hs = 1;
    applyStimulus(8'h0F, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rec16[15-i] = m_out;
      if (i == 1) checkOutput("b2b_hold_full_ready", {31'd0, m_ready}, 32'd0);
      if (i == 8) checkOutput("b2b_hold_pop_ready",  {31'd0, m_ready}, 32'd1);
      if (load_valid && model_ready()) hs++;
      tick();
      if (hs == 2) load_valid = 1'b0;
    end
    checkOutput("b2b_bits",       {16'd0, rec16}, 32'hF00F);
    checkOutput("b2b_handshakes", hs, 32'd2);
    checkOutput("b2b_idle",       {31'd0, m_valid}, 32'd0);
    tick();

    // Rate strobe: one bit_en in four, second word lands in hold mid-frame
    applyStimulus(8'hC3, 1'b1, 1'b0);
    tick();
    applyStimulus(8'hC3, 1'b0, 1'b0);
    for (int c = 0; c < 32; c++) begin
      bit_en = (c % 4 == 3);
      if (c == 5) begin
        din        = 8'h3C;
        load_valid = 1'b1;
      end
      if (c == 6) begin
        load_valid = 1'b0;
        checkOutput("strobe_hold_ready", {31'd0, m_ready}, 32'd0);
      end
      if (c % 4 == 0) rec8[7 - c/4] = m_out;
      tick();
    end
    checkOutput("strobe_bits",       {24'd0, rec8}, 32'hC3);
    checkOutput("strobe_next_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("strobe_next_bit",   {31'd0, m_out},   32'd0);
    bit_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // LSB-first instance with 0x01
    applyStimulus(8'h01, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rec8[i] = l_out;
      tick();
    end
    checkOutput("lsb_bits", {24'd0, rec8}, 32'h01);
    tick();

    // Boundary accept: word offered exactly on the last-bit edge
    applyStimulus(8'hFF, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(8'h55, 1'b1, 1'b1);
    checkOutput("bnd_ready_before", {31'd0, m_ready}, 32'd1);
    tick();
    load_valid = 1'b0;
    checkOutput("bnd_first_bit", {31'd0, m_out},   32'd0);
    checkOutput("bnd_valid",     {31'd0, m_valid}, 32'd1);
    checkOutput("bnd_ready",     {31'd0, m_ready}, 32'd1);
    checkOutput("bnd_lsb_first", {31'd0, l_out},   32'd1);
    tick();
    checkOutput("bnd_second_bit", {31'd0, m_out}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("final_idle", {31'd0, m_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
